// File: rtl/frame_display_sequencer.sv
// Validates frames captured by serial_decode, latches accepted payloads into a shadow
// register and cycles room/set/state bytes out to the BCD converter.
module frame_display_sequencer #(
  parameter logic [31:0] PREAMBLE_VALUE = 32'hAAAA_AAAA,
  parameter logic [31:0] CONSTANT_VALUE = 32'h0000_0000,
  parameter logic [7:0]  TAIL_VALUE     = 8'h00,
  parameter logic [23:0] DWELL_CYCLES   = 24'd10_000_000,
  parameter logic [31:0] STALE_CYCLES   = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_full,
  input  logic [31:0] preamble,
  input  logic [31:0] constant,
  input  logic [7:0]  tail_1,
  input  logic [7:0]  tail_2,
  input  logic [7:0]  tail_3,
  input  logic [15:0] room_temp,
  input  logic [15:0] set_temp,
  input  logic [7:0]  state,
  output logic        decoder_clear,
  output logic        bcd_start,
  output logic [7:0]  bcd_value,
  input  logic        bcd_busy,
  output logic [1:0]  field_select,
  output logic        frame_valid,
  output logic [7:0]  frame_count,
  output logic [7:0]  error_count
);

  typedef enum logic [1:0] {CAP_WAIT, CAP_CLEAR, CAP_HOLD} cap_state_t;
  typedef enum logic [1:0] {D_IDLE, D_LOAD, D_DWELL} disp_state_t;

  function automatic logic frame_matches(input logic [31:0] pre, input logic [31:0] cst,
                                         input logic [7:0] t1, input logic [7:0] t2,
                                         input logic [7:0] t3);
    return (pre == PREAMBLE_VALUE) && (cst == CONSTANT_VALUE) &&
           (t1 == TAIL_VALUE) && (t2 == TAIL_VALUE) && (t3 == TAIL_VALUE);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [1:0] next_field(input logic [1:0] f);
    logic [1:0] n;
    case (f)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  cap_state_t  cap_state_r;
  disp_state_t disp_state_r;

  logic        in_full_r;
  logic        in_match_r;
  logic [7:0]  in_room_r;
  logic [7:0]  in_set_r;
  logic [7:0]  in_state_r;
  logic [7:0]  shadow_room_r;
  logic [7:0]  shadow_set_r;
  logic [7:0]  shadow_state_r;
  logic [31:0] stale_cnt_r;
  logic [23:0] dwell_cnt_r;

  logic        accept_s;
  logic        stale_hit_s;
  logic        frame_valid_nxt_s;
  logic [7:0]  field_byte_s;
  logic        unused_hi_s;

  // Only the low bytes of the temperatures are ever displayed.
  assign unused_hi_s = ^{room_temp[15:8], set_temp[15:8]};

  // Acceptance, stale expiry and the next value of frame_valid
  always_comb begin
    accept_s    = 1'b0;
    stale_hit_s = 1'b0;
    if ((cap_state_r == CAP_WAIT) && in_full_r && in_match_r) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (frame_valid && (STALE_CYCLES != 32'd0) && (stale_cnt_r == STALE_CYCLES - 32'd1)) begin
      stale_hit_s = 1'b1;
    end else begin
      stale_hit_s = 1'b0;
    end
    if (accept_s) begin
      frame_valid_nxt_s = 1'b1;
    end else if (stale_hit_s) begin
      frame_valid_nxt_s = 1'b0;
    end else begin
      frame_valid_nxt_s = frame_valid;
    end
  end

  // Shadow byte addressed by the current display field
  always_comb begin
    case (field_select)
      2'd0:    field_byte_s = shadow_room_r;
      2'd1:    field_byte_s = shadow_set_r;
      2'd2:    field_byte_s = shadow_state_r;
      default: field_byte_s = 8'h00;
    endcase
  end

  // Input sampling stage: the frame is judged from one coherent snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_full_r  <= 1'b0;
      in_match_r <= 1'b0;
      in_room_r  <= 8'h00;
      in_set_r   <= 8'h00;
      in_state_r <= 8'h00;
    end else begin
      in_full_r  <= frame_full;
      in_match_r <= frame_matches(preamble, constant, tail_1, tail_2, tail_3);
      in_room_r  <= room_temp[7:0];
      in_set_r   <= set_temp[7:0];
      in_state_r <= state;
    end
  end

  // Capture FSM: one evaluation per frame, then clear the decoder and wait for full to drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_state_r    <= CAP_WAIT;
      decoder_clear  <= 1'b0;
      shadow_room_r  <= 8'h00;
      shadow_set_r   <= 8'h00;
      shadow_state_r <= 8'h00;
      frame_count    <= 8'h00;
      error_count    <= 8'h00;
    end else begin
      decoder_clear <= 1'b0;
      case (cap_state_r)
        CAP_WAIT: begin
          if (in_full_r) begin
            if (in_match_r) begin
              shadow_room_r  <= in_room_r;
              shadow_set_r   <= in_set_r;
              shadow_state_r <= in_state_r;
              frame_count    <= sat_inc(frame_count);
            end else begin
              error_count <= sat_inc(error_count);
            end
            decoder_clear <= 1'b1;
            cap_state_r   <= CAP_CLEAR;
          end
        end
        CAP_CLEAR: cap_state_r <= CAP_HOLD;
        CAP_HOLD: begin
          if (!in_full_r) begin
            cap_state_r <= CAP_WAIT;
          end
        end
        default: cap_state_r <= CAP_WAIT;
      endcase
    end
  end

  // Frame liveness: acceptance reloads the stale timer and wins over expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      stale_cnt_r <= 32'd0;
    end else begin
      frame_valid <= frame_valid_nxt_s;
      if (accept_s || stale_hit_s || !frame_valid || (STALE_CYCLES == 32'd0)) begin
        stale_cnt_r <= 32'd0;
      end else begin
        stale_cnt_r <= stale_cnt_r + 32'd1;
      end
    end
  end

  // Display FSM; follows the next frame_valid so the first request leaves one cycle after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_state_r <= D_IDLE;
      dwell_cnt_r  <= 24'd0;
      field_select <= 2'd0;
      bcd_start    <= 1'b0;
      bcd_value    <= 8'h00;
    end else begin
      bcd_start <= 1'b0;
      case (disp_state_r)
        D_IDLE: begin
          field_select <= 2'd0;
          if (frame_valid_nxt_s) begin
            disp_state_r <= D_LOAD;
          end
        end
        D_LOAD: begin
          if (!frame_valid_nxt_s) begin
            disp_state_r <= D_IDLE;
            field_select <= 2'd0;
          end else if (!bcd_busy) begin
            bcd_start    <= 1'b1;
            bcd_value    <= field_byte_s;
            dwell_cnt_r  <= DWELL_CYCLES - 24'd1;
            disp_state_r <= D_DWELL;
          end
        end
        D_DWELL: begin
          if (!frame_valid_nxt_s) begin
            disp_state_r <= D_IDLE;
            field_select <= 2'd0;
          end else if (dwell_cnt_r == 24'd0) begin
            field_select <= next_field(field_select);
            disp_state_r <= D_LOAD;
          end else begin
            dwell_cnt_r <= dwell_cnt_r - 24'd1;
          end
        end
        default: begin
          disp_state_r <= D_IDLE;
          field_select <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_display_sequencer.sv
// Scoreboard bench: a timeline model predicts decoder_clear, bcd_start and frame_valid
// events; a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_frame_display_sequencer;
  localparam logic [31:0] PRE   = 32'hAAAA_AAAA;
  localparam logic [31:0] CONST = 32'h0000_0000;
  localparam logic [7:0]  TAIL  = 8'h00;
  localparam int DWELL = 4;
  localparam int STALE = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_full = 1'b0;
  logic [31:0] preamble = 32'd0, constant = 32'd0;
  logic [7:0] tail_1 = 8'd0, tail_2 = 8'd0, tail_3 = 8'd0;
  logic [15:0] room_temp = 16'd0, set_temp = 16'd0;
  logic [7:0] state = 8'd0;
  logic bcd_busy = 1'b0;
  logic decoder_clear, bcd_start, frame_valid;
  logic [7:0] bcd_value, frame_count, error_count;
  logic [1:0] field_select;

  always #5 clk = ~clk;

  frame_display_sequencer #(
    .PREAMBLE_VALUE(PRE), .CONSTANT_VALUE(CONST), .TAIL_VALUE(TAIL),
    .DWELL_CYCLES(24'(DWELL)), .STALE_CYCLES(32'(STALE))
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_full(frame_full), .preamble(preamble),
    .constant(constant), .tail_1(tail_1), .tail_2(tail_2), .tail_3(tail_3),
    .room_temp(room_temp), .set_temp(set_temp), .state(state),
    .decoder_clear(decoder_clear), .bcd_start(bcd_start), .bcd_value(bcd_value),
    .bcd_busy(bcd_busy), .field_select(field_select), .frame_valid(frame_valid),
    .frame_count(frame_count), .error_count(error_count)
  );

  typedef struct {
    int edge_c; logic [31:0] pre; logic [31:0] cst;
    logic [7:0] t1; logic [7:0] t2; logic [7:0] t3;
    logic [15:0] room; logic [15:0] setp; logic [7:0] st;
  } frame_t;
  typedef struct { int cyc_c; logic [7:0] value; logic [1:0] field; } start_t;
  typedef struct { int cyc_c; logic [7:0] fc; logic [7:0] ec; logic fv; } clear_t;

  frame_t frame_q[$];
  start_t start_q[$];
  clear_t clear_q[$];
  int     fall_q[$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  bit busy_force = 1'b0;
  bit busy_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s at cycle %0d: got %s expected none", name, cyc, what);
  endtask

  // Reference model: cycle numbers of acceptance, expiry and display requests.
  initial begin : model
    frame_t fr;
    logic acc, got, vn, m_valid, m_active;
    int t, m_last_acc, m_next_req, m_field, m_fc, m_ec;
    logic [7:0] m_sh [3];
    m_valid = 0; m_active = 0; m_last_acc = 0; m_next_req = 0; m_field = 0;
    m_fc = 0; m_ec = 0; m_sh[0] = 0; m_sh[1] = 0; m_sh[2] = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      t = cyc;
      if (!rst_n) begin
        m_valid = 0; m_active = 0; m_fc = 0; m_ec = 0;
        m_sh[0] = 0; m_sh[1] = 0; m_sh[2] = 0;
        frame_q.delete(); start_q.delete(); clear_q.delete(); fall_q.delete();
      end else begin
        got = 0; acc = 0;
        if (frame_q.size() > 0 && frame_q[0].edge_c == t) begin
          fr = frame_q.pop_front();
          got = 1;
          acc = (fr.pre == PRE) && (fr.cst == CONST) && (fr.t1 == TAIL) &&
                (fr.t2 == TAIL) && (fr.t3 == TAIL);
        end
        if (acc) vn = 1;
        else if (m_valid && (t - m_last_acc == STALE)) vn = 0;
        else vn = m_valid;
        if (!vn) begin
          m_active = 0;
        end else if (!m_active) begin
          m_active = 1; m_field = 0; m_next_req = t + 1;
        end else if (t >= m_next_req && !bcd_busy) begin
          start_q.push_back('{cyc_c: t, value: m_sh[m_field], field: 2'(m_field)});
          m_field = (m_field + 1) % 3;
          m_next_req = t + DWELL + 1;
        end
        if (got) begin
          if (acc) begin
            m_sh[0] = fr.room[7:0]; m_sh[1] = fr.setp[7:0]; m_sh[2] = fr.st;
            m_last_acc = t;
            if (m_fc < 255) m_fc++;
          end else if (m_ec < 255) begin
            m_ec++;
          end
          clear_q.push_back('{cyc_c: t, fc: 8'(m_fc), ec: 8'(m_ec), fv: vn});
        end
        if (m_valid && !vn) fall_q.push_back(t);
        m_valid = vn;
      end
    end
  end

  // Monitor: compares each DUT event against the oldest prediction.
  initial begin : monitor
    start_t s; clear_t c; int f;
    logic prev_fv; logic [7:0] held;
    prev_fv = 0; held = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_fv = 0; held = 0;
      end else begin
        if (bcd_start) begin
          if (start_q.size() == 0) fail_event("bcd_start", "pulse");
          else begin
            s = start_q.pop_front();
            check("start_cycle", cyc, s.cyc_c);
            check("bcd_value", bcd_value, s.value);
            check("field_select", field_select, s.field);
            held = s.value;
          end
        end else begin
          check("bcd_value_hold", bcd_value, held);
        end
        if (decoder_clear) begin
          if (clear_q.size() == 0) fail_event("decoder_clear", "pulse");
          else begin
            c = clear_q.pop_front();
            check("clear_cycle", cyc, c.cyc_c);
            check("frame_count", frame_count, c.fc);
            check("error_count", error_count, c.ec);
            check("frame_valid_at_clear", frame_valid, c.fv);
          end
        end
        if (prev_fv && !frame_valid) begin
          if (fall_q.size() == 0) fail_event("frame_valid_fall", "fall");
          else begin
            f = fall_q.pop_front();
            check("fall_cycle", cyc, f);
            check("idle_field_select", field_select, 2'd0);
          end
        end
        prev_fv = frame_valid;
      end
    end
  end

  // Converter busy generator
  initial begin : busy_drv
    forever begin
      @(posedge clk); #1;
      if (busy_force) bcd_busy = 1'b1;
      else if (busy_rand) bcd_busy = ($urandom_range(0, 3) == 0);
      else bcd_busy = 1'b0;
    end
  end

  task automatic send_frame(input logic [31:0] pre, input logic [31:0] cst,
                            input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [15:0] room, input logic [15:0] setp,
                            input logic [7:0] st, input int hold, input int gap);
    @(posedge clk); #1;
    preamble = pre; constant = cst; tail_1 = a; tail_2 = b; tail_3 = c;
    room_temp = room; set_temp = setp; state = st; frame_full = 1'b1;
    frame_q.push_back('{edge_c: cyc + 2, pre: pre, cst: cst, t1: a, t2: b, t3: c,
                        room: room, setp: setp, st: st});
    repeat (hold) @(posedge clk);
    #1;
    frame_full = 1'b0;
    preamble = $urandom; constant = $urandom; tail_1 = 8'($urandom);
    room_temp = 16'($urandom); set_temp = 16'($urandom); state = 8'($urandom);
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic send_random(input bit good, input int hold, input int gap);
    logic [31:0] pre, cst; logic [7:0] a, b, c;
    pre = PRE; cst = CONST; a = TAIL; b = TAIL; c = TAIL;
    if (!good) begin
      case ($urandom_range(0, 4))
        0: pre = pre ^ (32'h1 << $urandom_range(0, 31));
        1: cst = cst ^ (32'h1 << $urandom_range(0, 31));
        2: a = a ^ (8'h1 << $urandom_range(0, 7));
        3: b = b ^ (8'h1 << $urandom_range(0, 7));
        default: c = c ^ (8'h1 << $urandom_range(0, 7));
      endcase
    end
    send_frame(pre, cst, a, b, c, 16'($urandom), 16'($urandom), 8'($urandom), hold, gap);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_decoder_clear"}, decoder_clear, 1'b0);
    check({tag, "_bcd_start"}, bcd_start, 1'b0);
    check({tag, "_bcd_value"}, bcd_value, 8'h00);
    check({tag, "_field_select"}, field_select, 2'd0);
    check({tag, "_frame_valid"}, frame_valid, 1'b0);
    check({tag, "_frame_count"}, frame_count, 8'h00);
    check({tag, "_error_count"}, error_count, 8'h00);
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Good frame then silence: 16,14,03,16 every DWELL+1 clocks, then stale expiry
    send_frame(PRE, CONST, TAIL, TAIL, TAIL, 16'h0016, 16'h0014, 8'h03, 5, 30);
    // Bad preamble: counted, no display activity
    send_frame(32'hAAAA_AAAB, CONST, TAIL, TAIL, TAIL, 16'h0099, 16'h0088, 8'h07, 5, 10);

    // Converter busy while a request is pending
    @(posedge clk); #1 busy_force = 1'b1;
    send_frame(PRE, CONST, TAIL, TAIL, TAIL, 16'h0021, 16'h0019, 8'h01, 2, 3);
    repeat (9) @(posedge clk);
    #1 busy_force = 1'b0;
    repeat (30) @(posedge clk);

    busy_rand = 1'b1;
    for (int i = 0; i < 400; i++)
      send_random($urandom_range(0, 9) < 6, $urandom_range(1, 5), $urandom_range(3, 30));

    for (int i = 0; i < 300; i++) send_random(1'b0, $urandom_range(1, 3), 3);
    repeat (5) @(posedge clk);
    #1 check("error_count_saturated", error_count, 8'd255);

    for (int i = 0; i < 260; i++) send_random(1'b1, 1, $urandom_range(3, 6));
    repeat (5) @(posedge clk);
    #1 check("frame_count_saturated", frame_count, 8'd255);

    busy_rand = 1'b0;
    repeat (40) @(posedge clk);
    // Asynchronous reset asserted mid-dwell
    send_frame(PRE, CONST, TAIL, TAIL, TAIL, 16'h0042, 16'h0037, 8'h02, 1, 3);
    #7 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    send_frame(PRE, CONST, TAIL, TAIL, TAIL, 16'h0031, 16'h0028, 8'h05, 3, 10);
    repeat (40) @(posedge clk);

    check("pending_starts", start_q.size(), 0);
    check("pending_clears", clear_q.size(), 0);
    check("pending_falls", fall_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/frame_display_sequencer.md
# frame_display_sequencer

Controller between `serial_decode` and the BCD/seven-segment display path. It watches the decoder's `full` flag and checks the fixed sections of each captured frame (preamble, constant, tails). Accepted frames are latched into a shadow register, and the decoder is cleared for the next transmission. It then cycles the display through room temperature, set temperature and state, driving the BCD converter with a start/busy handshake.

## Interface
Parameters:
- `PREAMBLE_VALUE`, default 32'hAAAA_AAAA: required `preamble` value.
- `CONSTANT_VALUE`, default 32'h0000_0000: required `constant` value.
- `TAIL_VALUE`, default 8'h00: required value of each of `tail_1`..`tail_3`.
- `DWELL_CYCLES`, default 24'd10_000_000: clocks each field stays displayed; minimum 1.
- `STALE_CYCLES`, default 32'd0: clocks without an accepted frame before `frame_valid` drops; 0 disables.

Ports:
- `clk`, in, 1: single clock; all state on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `frame_full`, in, 1: `serial_decode` full flag (level).
- `preamble`, in, 32; `constant`, in, 32: decoder fixed fields.
- `tail_1`, `tail_2`, `tail_3`, in, 8 each: decoder tail fields.
- `room_temp`, in, 16; `set_temp`, in, 16; `state`, in, 8: decoder payload.
- `decoder_clear`, out, 1: one-cycle pulse; OR'd into the decoder reset.
- `bcd_start`, out, 1: one-cycle request to the BCD converter.
- `bcd_value`, out, 8: byte to convert; held stable from `bcd_start` until the next `bcd_start`.
- `bcd_busy`, in, 1: converter is busy; requests are not issued while high.
- `field_select`, out, 2: 0 = room_temp[7:0], 1 = set_temp[7:0], 2 = state; 3 is never driven.
- `frame_valid`, out, 1: shadow register holds a live accepted frame.
- `frame_count`, out, 8: accepted frames, saturates at 255.
- `error_count`, out, 8: rejected frames, saturates at 255.

## Operation
- Reset: every output is 0, the shadow register is 0, and both FSMs are in their first state.
- Capture FSM, states WAIT → CLEAR → HOLD → WAIT:
  - WAIT with `frame_full`=1: evaluate `match` = all of preamble, constant and the three tails equal their parameter values.
    - `match`=1: load the shadow register (room, set, state), increment `frame_count`, set `frame_valid`=1, reload the stale timer.
    - `match`=0: increment `error_count`; shadow and `frame_valid` are unchanged.
    - Either way, go to CLEAR.
  - CLEAR: `decoder_clear`=1 for exactly this cycle; go to HOLD.
  - HOLD: stay until `frame_full`=0, then go to WAIT. This guarantees one evaluation per frame.
- Stale timer: counts up while `frame_valid`=1. When it reaches `STALE_CYCLES` (if nonzero), clear `frame_valid`. An acceptance in that same cycle wins: `frame_valid` stays 1 and the timer reloads to 0.
- Display FSM, states D_IDLE, D_LOAD, D_DWELL:
  - D_IDLE: `field_select`=0. Go to D_LOAD when `frame_valid`=1.
  - D_LOAD: if `bcd_busy`=0, pulse `bcd_start`, register `bcd_value` from the selected shadow byte, load the dwell counter with `DWELL_CYCLES`-1, and go to D_DWELL. If `bcd_busy`=1, stay in D_LOAD with no pulse.
  - D_DWELL: decrement the counter. At 0, advance `field_select` (0→1→2→0) and go to D_LOAD.
  - From D_LOAD or D_DWELL: if `frame_valid`=0, go to D_IDLE and set `field_select`=0. This check has priority over all other transitions.
- A new frame accepted mid-dwell updates the shadow only. `bcd_value` does not change until the next D_LOAD.
- Reset asserted mid-frame or mid-dwell: immediate return to reset values. No `decoder_clear` pulse is emitted on exit from reset.

## Timing
- `frame_full` sampled high at edge N:
  - Shadow, counters and `frame_valid` update at edge N+1.
  - `decoder_clear` is high from edge N+1 to edge N+2.
  - The next evaluation occurs no earlier than the first edge at which `frame_full`=0 is sampled in HOLD, plus one.
- `frame_valid` rises at edge N+1: first `bcd_start` at edge N+2, if `bcd_busy`=0.
- Consecutive `bcd_start` pulses are `DWELL_CYCLES`+1 clocks apart when `bcd_busy` stays 0.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Good frame (preamble AAAA_AAAA, constant 0, tails 00, room 16'h0016, set 16'h0014, state 8'h03), `frame_full` held 5 cycles → `frame_count`=1, one `decoder_clear` pulse, `bcd_value`=8'h16 with `field_select`=0.
- Frame with preamble AAAA_AAAB → `error_count`=1, `frame_valid` stays 0, `decoder_clear` still pulses once, no `bcd_start`.
- `DWELL_CYCLES`=4, valid frame, `bcd_busy`=0 → `bcd_value` sequence 16,14,03,16 with `bcd_start` every 5 clocks.
- `bcd_busy` held 1 for 10 cycles in D_LOAD → no `bcd_start` until the cycle after `bcd_busy` falls; `bcd_value` updates with that pulse.
- `STALE_CYCLES`=20, one valid frame, then none → `frame_valid` falls 20 clocks after acceptance; display returns to D_IDLE with `field_select`=0.
- 300 bad frames → `error_count` saturates at 255; `rst_n` pulsed mid-dwell → all outputs 0 asynchronously.
